// File: rtl/addsub_seq_ctrl.sv
// rtl/addsub_seq_ctrl.sv - handshake sequencer around a combinational 4-bit add/sub unit
// Registers operands into the adder, waits a settle window, then holds the captured result downstream.
module addsub_seq_ctrl #(
   parameter int WIDTH      = 4,
   parameter int SETTLE_CYC = 1,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_mode,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_cin,
   output logic             add_mode,
   input  logic [WIDTH:0]   add_sum,
   input  logic             add_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   res_sum,
   output logic             res_cout,
   output logic             res_mode,
   output logic             res_zero,
   output logic [CNT_W-1:0] op_cnt
);

   // A zero settle window would capture before the adder sees its operands.
   localparam int SC  = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
   localparam int SCW = (SC > 1) ? $clog2(SC) : 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   logic [1:0]     state;
   logic [SCW-1:0] settle_cnt;
   logic           accept;

   assign out_valid = (state == DONE);
   assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         settle_cnt <= '0;
         add_a      <= '0;
         add_b      <= '0;
         add_cin    <= 1'b0;
         add_mode   <= 1'b0;
         res_sum    <= '0;
         res_cout   <= 1'b0;
         res_mode   <= 1'b0;
         res_zero   <= 1'b0;
         op_cnt     <= '0;
      end else begin
         // Operands move only on an accepting edge, so in_* outside handshakes never reach the adder.
         if (accept) begin
            add_a      <= in_a;
            add_b      <= in_b;
            add_cin    <= in_cin;
            add_mode   <= in_mode;
            settle_cnt <= SCW'(SC - 1);
         end
         case (state)
            IDLE: begin
               if (accept) state <= SETTLE;
            end
            SETTLE: begin
               if (settle_cnt == '0) begin
                  res_sum  <= add_sum;
                  res_cout <= add_cout;
                  res_mode <= add_mode;
                  res_zero <= (add_sum == '0);
                  state    <= DONE;
               end else begin
                  settle_cnt <= settle_cnt - SCW'(1);
               end
            end
            DONE: begin
               // A pop with a new operation pending goes straight back to SETTLE.
               if (out_ready) begin
                  op_cnt <= op_cnt + CNT_W'(1);
                  state  <= in_valid ? SETTLE : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
